// File: rtl/integral_image_gen.sv
// integral_image_gen: turns a raster pixel stream into summed-area image writes (addr = running counter).
// Define II_ZERO_BORDER_EN to emit a zero top row and left column (grid (W+1)x(H+1), stride W+1).
module integral_image_gen #(
  parameter int MAX_W  = 96,
  parameter int PIX_W  = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              ii_valid,
  input  logic              ii_ready,
  output logic [ADDR_W-1:0] ii_addr,
  output logic [ACC_W-1:0]  ii_data,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(MAX_W + 1);
  localparam logic [15:0] MAX16 = 16'(MAX_W);
`ifdef II_ZERO_BORDER_EN
  localparam bit BORDER = 1'b1;
  typedef enum logic [2:0] {IDLE, ZROW, RUN, DRAIN, DONE} state_t;
`else
  localparam bit BORDER = 1'b0;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d, w_in, h_in;
  logic [ACC_W-1:0] row_sum_q, row_sum_d, rs, above, ii;
  logic [ACC_W-1:0] line_buf_q [MAX_W];
  logic [ADDR_W-1:0] addr_q, addr_d, ii_addr_q, ii_addr_d;
  logic [ACC_W-1:0] ii_data_q, ii_data_d;
  logic ii_valid_q, ii_valid_d, bz_q, bz_d;
  logic load_ok, pix_acc, lb_we, last_x, last_y;

  assign ii_valid = ii_valid_q;
  assign ii_addr  = ii_addr_q;
  assign ii_data  = ii_data_q;
  assign busy     = state_q != IDLE && state_q != DONE;
  assign done     = state_q == DONE;

  always_comb begin
    w_in = width > MAX16 ? CW'(MAX_W) : CW'(width);
    h_in = height > MAX16 ? CW'(MAX_W) : CW'(height);
    load_ok = !ii_valid_q || ii_ready;
    // bz_q marks a pending left-border zero write, which blocks pixel intake
    pix_ready = state_q == RUN && !bz_q && load_ok;
    pix_acc = pix_valid && pix_ready;
    last_x = x_q == w_q - 1'b1;
    last_y = y_q == h_q - 1'b1;
    rs = (x_q == '0 ? '0 : row_sum_q) + ACC_W'(pix_data);
    above = y_q == '0 ? '0 : line_buf_q[x_q];
    ii = rs + above;
    state_d = state_q;
    w_d = w_q;
    h_d = h_q;
    x_d = x_q;
    y_d = y_q;
    row_sum_d = row_sum_q;
    addr_d = addr_q;
    bz_d = bz_q;
    ii_valid_d = ii_valid_q && !ii_ready;
    ii_addr_d = ii_addr_q;
    ii_data_d = ii_data_q;
    lb_we = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        w_d = w_in;
        h_d = h_in;
        x_d = '0;
        y_d = '0;
        addr_d = '0;
        bz_d = 1'b0;
`ifdef II_ZERO_BORDER_EN
        state_d = (w_in == '0 || h_in == '0) ? DONE : ZROW;
`else
        state_d = (w_in == '0 || h_in == '0) ? DONE : RUN;
`endif
      end
`ifdef II_ZERO_BORDER_EN
      ZROW: if (load_ok) begin
        ii_valid_d = 1'b1;
        ii_addr_d = addr_q;
        ii_data_d = '0;
        addr_d = addr_q + 1'b1;
        x_d = x_q == w_q ? '0 : x_q + 1'b1;
        bz_d = x_q == w_q;
        state_d = x_q == w_q ? RUN : ZROW;
      end
`endif
      RUN: if (bz_q && load_ok) begin
        ii_valid_d = 1'b1;
        ii_addr_d = addr_q;
        ii_data_d = '0;
        addr_d = addr_q + 1'b1;
        bz_d = 1'b0;
      end else if (pix_acc) begin
        ii_valid_d = 1'b1;
        ii_addr_d = addr_q;
        ii_data_d = ii;
        addr_d = addr_q + 1'b1;
        row_sum_d = rs;
        lb_we = 1'b1;
        x_d = last_x ? '0 : x_q + 1'b1;
        y_d = last_x ? y_q + 1'b1 : y_q;
        bz_d = BORDER && last_x && !last_y;
        state_d = last_x && last_y ? DRAIN : RUN;
      end
      DRAIN: state_d = (ii_valid_q && ii_ready) ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      w_q <= '0;
      h_q <= '0;
      x_q <= '0;
      y_q <= '0;
      row_sum_q <= '0;
      addr_q <= '0;
      bz_q <= 1'b0;
      ii_valid_q <= 1'b0;
      ii_addr_q <= '0;
      ii_data_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      h_q <= h_d;
      x_q <= x_d;
      y_q <= y_d;
      row_sum_q <= row_sum_d;
      addr_q <= addr_d;
      bz_q <= bz_d;
      ii_valid_q <= ii_valid_d;
      ii_addr_q <= ii_addr_d;
      ii_data_q <= ii_data_d;
    end

  // Line buffer is never cleared; row 0 ignores it through the y==0 select
  always_ff @(posedge clk)
    if (lb_we) line_buf_q[x_q] <= ii;
endmodule
